// File: rtl/packet_arbiter.sv
// packet_arbiter: merges valid/ready streams into one, tagging the source index in the header.
// Define PACKET_ARBITER_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module packet_arbiter #(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_ninputs-1:0]                  valid,
  output logic [p_ninputs-1:0]                  ready,
  input  logic [p_nbits-$clog2(p_ninputs)-1:0]  message_in [p_ninputs],
  output logic                                  valid_out,
  input  logic                                  ready_out,
  output logic [p_nbits-1:0]                    message_out
);

  localparam int H = $clog2(p_ninputs);
  localparam int W = p_nbits - H;

  logic         full_q, full_d;
  logic [H-1:0] hdr_q, hdr_d;
  logic [W-1:0] pay_q, pay_d;
  logic [H-1:0] ptr;

  logic [p_ninputs-1:0] grant;
  logic [H-1:0]         gidx;
  logic [H-1:0]         idx;
  logic                 found;
  logic                 can_accept;
  logic                 xfer;

`ifdef PACKET_ARBITER_RR_EN
  logic [H-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  // Scan upward from ptr; H-bit arithmetic wraps because p_ninputs is 2^H.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < p_ninputs; k++) begin
      idx = ptr + H'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  assign can_accept = !full_q || ready_out;
  assign ready      = (can_accept && !reset) ? grant : '0;
  assign xfer       = found && can_accept && !reset;

  always_comb begin
    full_d = full_q;
    hdr_d  = hdr_q;
    pay_d  = pay_q;
    if (xfer) begin
      full_d = 1'b1;
      hdr_d  = gidx;
      pay_d  = message_in[gidx];
    end else if (ready_out) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      hdr_q  <= '0;
      pay_q  <= '0;
    end else begin
      full_q <= full_d;
      hdr_q  <= hdr_d;
      pay_q  <= pay_d;
    end
  end

  assign valid_out   = full_q;
  assign message_out = {hdr_q, pay_q};

endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed checks of packet_arbiter (32-bit, 8 inputs).
// Expectations follow PACKET_ARBITER_RR_EN when the bench is built with it.
module tb_packet_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  valid;
  logic [7:0]  ready;
  logic [28:0] message_in [8];
  logic        valid_out;
  logic        ready_out;
  logic [31:0] message_out;

  int errors;
  int checks;

  packet_arbiter #(.p_nbits(32), .p_ninputs(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .ready       (ready),
    .message_in  (message_in),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .message_out (message_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = '0;
    ready_out = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 8'hFF;
    ready_out = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ready !== 8'h00) begin
        errors++;
        $display("FAIL reset_ready c=%0d got=%h exp=00", c, ready);
      end
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid_out c=%0d got=%b exp=0", c, valid_out);
      end
      checks++;
      if (message_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_msg c=%0d got=%h exp=0", c, message_out);
      end
    end
    valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    valid = 8'h20;
    message_in[5] = 29'h0ABCDEF;
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready !== 8'h20) begin
      errors++;
      $display("FAIL single_ready got=%h exp=20", ready);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (valid_out !== 1'b1 || message_out !== 32'hA0ABCDEF) begin
      errors++;
      $display("FAIL single_out got=%b/%h exp=1/a0abcdef", valid_out, message_out);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got=%b exp=0", valid_out);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]  exp_rdy;
    logic [31:0] exp_msg;
    int          g, prev;
    do_reset();
    for (int i = 0; i < 8; i++) message_in[i] = 29'h100 + 29'(i);
    prev = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      valid = 8'hFF;
      ready_out = 1'b1;
      #1;
`ifdef PACKET_ARBITER_RR_EN
      g = c % 8;
`else
      g = 0;
`endif
      exp_rdy = 8'h01 << g;
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant c=%0d got=%h exp=%h", c, ready, exp_rdy);
      end
      if (prev >= 0) begin
        exp_msg = {3'(prev), 29'h100 + 29'(prev)};
        checks++;
        if (valid_out !== 1'b1 || message_out !== exp_msg) begin
          errors++;
          $display("FAIL rr_out c=%0d got=%b/%h exp=1/%h", c, valid_out, message_out, exp_msg);
        end
      end
      prev = g;
    end
    @(negedge clk);
    valid = '0;
    exp_msg = {3'(prev), 29'h100 + 29'(prev)};
    checks++;
    if (valid_out !== 1'b1 || message_out !== exp_msg) begin
      errors++;
      $display("FAIL rr_last got=%b/%h exp=1/%h", valid_out, message_out, exp_msg);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_b;
    exp_a = {3'd3, 29'h1234567};
    exp_b = {3'd3, 29'h0765432};
    do_reset();
    @(negedge clk);
    valid = 8'h08;
    message_in[3] = 29'h1234567;
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready !== 8'h08) begin
      errors++;
      $display("FAIL bp_first_ready got=%h exp=08", ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ready_out = 1'b0;
      message_in[3] = 29'h0765432;
      #1;
      checks++;
      if (ready !== 8'h00) begin
        errors++;
        $display("FAIL bp_ready c=%0d got=%h exp=00", c, ready);
      end
      checks++;
      if (valid_out !== 1'b1 || message_out !== exp_a) begin
        errors++;
        $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, valid_out, message_out, exp_a);
      end
    end
    @(negedge clk);
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready !== 8'h08 || message_out !== exp_a) begin
      errors++;
      $display("FAIL bp_release got=%h/%h exp=08/%h", ready, message_out, exp_a);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (valid_out !== 1'b1 || message_out !== exp_b) begin
      errors++;
      $display("FAIL bp_next got=%b/%h exp=1/%h", valid_out, message_out, exp_b);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_nodup got=%b exp=0", valid_out);
    end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] exp_seq [3];
`ifdef PACKET_ARBITER_RR_EN
    exp_seq = '{8'h04, 8'h80, 8'h04};
`else
    exp_seq = '{8'h04, 8'h04, 8'h04};
`endif
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid = 8'h84;
      ready_out = 1'b1;
      #1;
      checks++;
      if (ready !== exp_seq[c]) begin
        errors++;
        $display("FAIL prio_grant c=%0d got=%h exp=%h", c, ready, exp_seq[c]);
      end
    end
    @(negedge clk);
    valid = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    valid = 8'h08;
    message_in[3] = 29'h00000AA;
    ready_out = 1'b1;
    @(negedge clk);
    valid = '0;
    ready_out = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_full got=%b exp=1", valid_out);
    end
    @(negedge clk);
    reset = 1'b1;
    valid = 8'hFF;
    #1;
    checks++;
    if (ready !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_ready got=%h exp=00", ready);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || message_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_discard got=%b/%h exp=0/0", valid_out, message_out);
    end
    reset = 1'b0;
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready !== 8'h01) begin
      errors++;
      $display("FAIL mid_first_grant got=%h exp=01", ready);
    end
    @(negedge clk);
    valid = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    valid = '0;
    ready_out = 1'b0;
    for (int i = 0; i < 8; i++) message_in[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
